// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: decode issue/hazard, two writeback
// requesters, and the register-file write port with status.
//   master: issue + requesters side (drives requests, sees stall/ready/write port)
//   slave : scheduler side (computes stall/ready, owns write port and status)
interface regfile_wb_scheduler_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     flush;
    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic                     issue_stall;
    logic                     a_valid;
    logic [ADDRESS_WIDTH-1:0] a_rd;
    logic [DATA_WIDTH:0]      a_data;
    logic                     a_ready;
    logic                     b_valid;
    logic [ADDRESS_WIDTH-1:0] b_rd;
    logic [DATA_WIDTH:0]      b_data;
    logic                     b_ready;
    logic                     we3;
    logic [ADDRESS_WIDTH-1:0] ad3;
    logic [DATA_WIDTH:0]      wd3;
    logic [ADDRESS_WIDTH:0]   busy_count;
    logic                     wb_unexpected;

    modport master (
        output flush, issue_valid, issue_rd, rs1, rs2,
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  issue_stall, a_ready, b_ready,
        input  we3, ad3, wd3, busy_count, wb_unexpected
    );

    modport slave (
        input  flush, issue_valid, issue_rd, rs1, rs2,
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output issue_stall, a_ready, b_ready,
        output we3, ad3, wd3, busy_count, wb_unexpected
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin A/B writeback arbiter,
// one-cycle write stage and per-register pending-write scoreboard.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): issue/stall, A/B valid-ready requesters, we3/ad3/wd3,
//                busy_count, sticky wb_unexpected
module regfile_wb_scheduler #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave bus
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;

    logic [NREG-1:0]          r_busy;
    logic [NREG-1:0]          w_busy_nxt;
    logic                     r_prefer_b;
    logic                     r_we3;
    logic [ADDRESS_WIDTH-1:0] r_ad3;
    logic [DATA_WIDTH:0]      r_wd3;
    logic [ADDRESS_WIDTH:0]   r_busy_count;
    logic [ADDRESS_WIDTH:0]   w_count_nxt;
    logic                     r_unexp;

    logic                     w_stall;
    logic                     w_set;
    logic                     w_a_grant;
    logic                     w_b_grant;
    logic                     w_xfer;
    logic [ADDRESS_WIDTH-1:0] w_x_rd;
    logic [DATA_WIDTH:0]      w_x_data;
    logic                     w_x_nz;
    logic                     w_unexp;

    // busy[0] is never set, so x0 reads never stall
    assign w_stall = bus.issue_valid
                   & (r_busy[bus.rs1] | r_busy[bus.rs2]
                   | r_busy[bus.issue_rd]);

    assign w_set = bus.issue_valid & ~w_stall
                 & (bus.issue_rd != '0);

    // Grant the lone requester, or on contention the one
    // not granted on the previous transfer.
    assign w_a_grant = bus.a_valid & (~bus.b_valid | ~r_prefer_b);
    assign w_b_grant = bus.b_valid & (~bus.a_valid | r_prefer_b);
    assign w_xfer    = w_a_grant | w_b_grant;
    assign w_x_rd    = w_a_grant ? bus.a_rd : bus.b_rd;
    assign w_x_data  = w_a_grant ? bus.a_data : bus.b_data;
    assign w_x_nz    = (w_x_rd != '0);
    assign w_unexp   = w_xfer & w_x_nz & ~r_busy[w_x_rd];

    // Order matters: clear, then set (set wins), then flush
    // overrides everything.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3) begin
            w_busy_nxt[r_ad3] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_count_nxt = w_count_nxt
                        + {{ADDRESS_WIDTH{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_prefer_b   <= 1'b0;
            r_we3        <= 1'b0;
            r_ad3        <= '0;
            r_wd3        <= '0;
            r_busy_count <= '0;
            r_unexp      <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
            if (w_a_grant) begin
                r_prefer_b <= 1'b1;
            end else if (w_b_grant) begin
                r_prefer_b <= 1'b0;
            end
            // x0 transfers complete but never raise we3
            r_we3 <= w_xfer & w_x_nz;
            if (w_xfer) begin
                r_ad3 <= w_x_rd;
                r_wd3 <= w_x_data;
            end
            if (w_unexp) begin
                r_unexp <= 1'b1;
            end
        end
    end

    assign bus.issue_stall   = w_stall;
    assign bus.a_ready       = w_a_grant;
    assign bus.b_ready       = w_b_grant;
    assign bus.we3           = r_we3;
    assign bus.ad3           = r_ad3;
    assign bus.wd3           = r_wd3;
    assign bus.busy_count    = r_busy_count;
    assign bus.wb_unexpected = r_unexp;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed stimulus, expected
// register-file writes queued at issue and checked by a write monitor.
module tb_regfile_wb_scheduler;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] ad;
        logic [DW:0]   wd;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];

    regfile_wb_scheduler_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    regfile_wb_scheduler #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input int rd,
                         input int r1, input int r2);
        bus.issue_valid = v;
        bus.issue_rd    = AW'(rd);
        bus.rs1         = AW'(r1);
        bus.rs2         = AW'(r2);
    endtask

    task automatic req_a(input logic v, input int rd, input logic [DW:0] d);
        bus.a_valid = v;
        bus.a_rd    = AW'(rd);
        bus.a_data  = d;
    endtask

    task automatic req_b(input logic v, input int rd, input logic [DW:0] d);
        bus.b_valid = v;
        bus.b_rd    = AW'(rd);
        bus.b_data  = d;
    endtask

    task automatic push(input int rd, input logic [DW:0] d);
        wr_t e;
        e.ad = AW'(rd);
        e.wd = d;
        exp_q.push_back(e);
    endtask

    // Write-port monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_exclusive", 64'(bus.a_ready & bus.b_ready), 0);
            chk("a_ready_wo_valid", 64'(bus.a_ready & ~bus.a_valid), 0);
            chk("b_ready_wo_valid", 64'(bus.b_ready & ~bus.b_valid), 0);
            if (bus.we3) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_we3 actual=ad3:%0h required=no write",
                             bus.ad3);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_ad3", 64'(bus.ad3), 64'(e.ad));
                    chk("wr_wd3", 64'(bus.wd3), 64'(e.wd));
                end
            end
        end
    end

    int ta_rd[5] = '{1, 2, 2, 5, 5};
    int tb_v[5]  = '{1, 1, 1, 1, 0};
    int tb_rd[5] = '{3, 3, 4, 4, 4};
    int ex_a[5]  = '{1, 0, 1, 0, 1};

    initial begin
        bus.flush = 1'b0;
        issue(0, 0, 0, 0);
        req_a(0, 0, '0);
        req_b(0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we3", 64'(bus.we3), 0);
        chk("rst_ad3", 64'(bus.ad3), 0);
        chk("rst_wd3", 64'(bus.wd3), 0);
        chk("rst_busy_count", 64'(bus.busy_count), 0);
        chk("rst_unexp", 64'(bus.wb_unexpected), 0);
        rst_n = 1'b1;

        // Basic issue / writeback / clear
        tick(); issue(1, 5, 0, 0);
        @(negedge clk); chk("t1_issue_stall", 64'(bus.issue_stall), 0);
        tick(); issue(0, 0, 0, 0);
        @(negedge clk); chk("t1_busy_count", 64'(bus.busy_count), 1);
        tick();
        tick(); req_a(1, 5, 33'h1234); push(5, 33'h1234);
        @(negedge clk); chk("t1_a_ready", 64'(bus.a_ready), 1);
        tick(); req_a(0, 0, '0); issue(1, 0, 5, 0);
        @(negedge clk);
        chk("t1_we3", 64'(bus.we3), 1);
        chk("t1_stall_wb", 64'(bus.issue_stall), 1);
        chk("t1_busy_wb", 64'(bus.busy_count), 1);
        tick();
        @(negedge clk);
        chk("t1_unstall", 64'(bus.issue_stall), 0);
        chk("t1_busy_clr", 64'(bus.busy_count), 0);
        tick(); issue(0, 0, 0, 0);

        // RAW / WAW stall
        tick(); issue(1, 7, 0, 0);
        tick(); issue(1, 0, 7, 0);
        @(negedge clk); chk("t2_raw", 64'(bus.issue_stall), 1);
        tick(); issue(1, 7, 0, 0);
        @(negedge clk); chk("t2_waw", 64'(bus.issue_stall), 1);
        tick(); issue(1, 0, 7, 0); req_a(1, 7, 33'h77); push(7, 33'h77);
        @(negedge clk); chk("t2_a_ready", 64'(bus.a_ready), 1);
        tick(); req_a(0, 0, '0);
        @(negedge clk); chk("t2_stall_wb", 64'(bus.issue_stall), 1);
        tick();
        @(negedge clk); chk("t2_unstall", 64'(bus.issue_stall), 0);
        tick(); issue(0, 0, 0, 0);

        // Write to x0
        tick(); req_a(1, 0, 33'hFF); issue(1, 0, 0, 0);
        @(negedge clk);
        chk("t4_a_ready", 64'(bus.a_ready), 1);
        chk("t4_x0_nostall", 64'(bus.issue_stall), 0);
        tick(); req_a(0, 0, '0); issue(0, 0, 0, 0);
        @(negedge clk);
        chk("t4_we3", 64'(bus.we3), 0);
        chk("t4_unexp", 64'(bus.wb_unexpected), 0);

        // Unexpected writeback via B (pointer now prefers B)
        tick(); req_b(1, 9, 33'h99); push(9, 33'h99);
        @(negedge clk);
        chk("t5_b_ready", 64'(bus.b_ready), 1);
        chk("t5_a_ready", 64'(bus.a_ready), 0);
        tick(); req_b(0, 0, '0);
        @(negedge clk); chk("t5_unexp", 64'(bus.wb_unexpected), 1);
        tick();
        @(negedge clk); chk("t5_unexp_sticky", 64'(bus.wb_unexpected), 1);

        // Contention: pointer prefers A after the B transfer
        for (int r = 1; r <= 5; r++) begin
            tick(); issue(1, r, 0, 0);
        end
        tick(); issue(0, 0, 0, 0);
        @(negedge clk); chk("t3_busy5", 64'(bus.busy_count), 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            req_a(1, ta_rd[i], 33'h100 + 33'(ta_rd[i]));
            req_b(tb_v[i] != 0, tb_rd[i], 33'h200 + 33'(tb_rd[i]));
            if (ex_a[i] != 0) push(ta_rd[i], 33'h100 + 33'(ta_rd[i]));
            else push(tb_rd[i], 33'h200 + 33'(tb_rd[i]));
            @(negedge clk);
            chk($sformatf("t3_a_ready%0d", i), 64'(bus.a_ready), 64'(ex_a[i]));
            chk($sformatf("t3_b_ready%0d", i), 64'(bus.b_ready),
                64'(ex_a[i] == 0));
            if (i > 0) chk($sformatf("t3_we3_%0d", i), 64'(bus.we3), 1);
        end
        tick(); req_a(0, 0, '0); req_b(0, 0, '0);
        repeat (2) tick();
        @(negedge clk); chk("t3_busy_clr", 64'(bus.busy_count), 0);

        // Flush with staged write, then async reset
        tick(); issue(1, 3, 0, 0);
        tick(); issue(1, 4, 0, 0);
        tick(); issue(0, 0, 0, 0);
        req_a(1, 3, 33'h333); push(3, 33'h333); bus.flush = 1'b1;
        @(negedge clk); chk("t6_a_ready", 64'(bus.a_ready), 1);
        tick(); req_a(0, 0, '0); bus.flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_busy", 64'(bus.busy_count), 0);
        chk("t6_flush_we3", 64'(bus.we3), 1);
        tick(); req_a(1, 12, 33'hC);
        @(negedge clk); chk("t6_a12_ready", 64'(bus.a_ready), 1);
        tick(); req_a(0, 0, '0);
        #2;
        chk("t6_we3_pre_rst", 64'(bus.we3), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we3", 64'(bus.we3), 0);
        chk("t6_rst_busy", 64'(bus.busy_count), 0);
        chk("t6_rst_unexp", 64'(bus.wb_unexpected), 0);
        @(negedge clk); rst_n = 1'b1;
        tick(); req_a(1, 0, 33'h1); req_b(1, 0, 33'h2);
        @(negedge clk);
        chk("t6_grant_a", 64'(bus.a_ready), 1);
        chk("t6_grant_b", 64'(bus.b_ready), 0);
        tick(); req_a(0, 0, '0); req_b(0, 0, '0);
        repeat (2) tick();
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port (WE3/AD3/WD3) of the 32-entry register file. Arbitrates it between two writeback requesters: A (single-cycle ALU path) and B (multi-cycle load/mul path).
- Holds a per-register pending-write scoreboard. Decode stalls on RAW/WAW hazards against it, so no bypass network is needed.
- Sits between the execute/memory stages and the register file.

Parameters:
ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH scoreboard entries.
DATA_WIDTH, 32, data ports are DATA_WIDTH+1 bits wide, matching the register file write-data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of all scoreboard bits.
issue_valid  in  1  decode issuing an instruction that will write issue_rd.
issue_rd  in  ADDRESS_WIDTH  destination of issuing instruction.
rs1  in  ADDRESS_WIDTH  source 1 of issuing instruction.
rs2  in  ADDRESS_WIDTH  source 2 of issuing instruction.
issue_stall  out  1  combinational hazard stall to decode.
a_valid  in  1  requester A has a result.
a_rd  in  ADDRESS_WIDTH  A destination.
a_data  in  DATA_WIDTH+1  A result.
a_ready  out  1  A transfer accepted this cycle.
b_valid  in  1  requester B has a result.
b_rd  in  ADDRESS_WIDTH  B destination.
b_data  in  DATA_WIDTH+1  B result.
b_ready  out  1  B transfer accepted this cycle.
we3  out  1  register file write enable (registered).
ad3  out  ADDRESS_WIDTH  register file write address (registered).
wd3  out  DATA_WIDTH+1  register file write data (registered).
busy_count  out  ADDRESS_WIDTH+1  number of set scoreboard bits (registered).
wb_unexpected  out  1  sticky: a writeback arrived for a non-busy, nonzero register.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs and state go to zero: scoreboard, we3, ad3, wd3, busy_count, wb_unexpected.
  - Round-robin pointer goes to "A preferred".
  - Any staged write in flight is discarded.
- Scoreboard busy[i], i=1..2**ADDRESS_WIDTH-1. busy[0] is hardwired 0.
- Stall:
  - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[issue_rd]).
  - Covers RAW and WAW. Reads of x0 never stall.
- Set: on an edge with issue_valid & ~issue_stall & issue_rd!=0, busy[issue_rd] <= 1.
- Arbitration (combinational grant, same cycle):
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the requester not granted on the last transfer; then update the pointer.
  - At most one of a_ready/b_ready is high in any cycle.
  - ready is never high without the matching valid.
  - Requesters hold valid, rd and data stable until ready.
- Write stage, 1-cycle latency:
  - A transfer in cycle N drives we3=1, ad3=rd, wd3=data in cycle N+1.
  - With no transfer, we3=0 and ad3/wd3 hold their last values.
  - If rd==0, the transfer completes (ready=1) but we3 stays 0 in N+1.
- Clear:
  - busy[ad3] <= 0 on the edge ending cycle N+1, the same edge on which the register file commits.
  - The stall on that register drops in N+2, when the read port returns the new value.
- Set and clear of the same index on the same edge: set wins. This is unreachable under the WAW stall and is kept only as a safety rule.
- wb_unexpected: set at transfer time when rd!=0 & ~busy[rd]. The write still proceeds. Cleared only by reset.
- flush:
  - Clears every busy bit on that edge. It overrides a same-edge set; issue is ignored.
  - A staged write already in the write stage still completes on we3.
- busy_count: registered population count of the scoreboard after the edge's updates. Maximum value is 31.
- Throughput: one writeback per cycle sustained. Requests are never dropped; a request waits at most one cycle under contention.

Test Plan:
- Reset then issue rd=5, then A writes rd=5 data=0x1234 two cycles later -> busy_count=1 after issue; a_ready=1 on the transfer cycle; we3=1, ad3=5, wd3=0x1234 next cycle; busy_count=0 and rs1=5 unstalled in the cycle after that.
- Issue rd=7, then issue rs1=7 -> issue_stall=1 until the cycle after we3 writes ad3=7; issue rd=7 again while busy -> stalled (WAW).
- A and B both valid every cycle for 4 cycles (rd=1,2 / 3,4 pre-issued) -> grants alternate A,B,A,B; one we3 per cycle; no cycle with both ready high.
- A writes rd=0 with data=0xFF -> a_ready=1, we3 stays 0, wb_unexpected stays 0; issue rs1=0 never stalls.
- B writes rd=9 with busy[9]=0 -> write occurs (ad3=9), wb_unexpected=1 and stays 1 until rst_n asserted.
- Issue rd=3 and rd=4, transfer A rd=3, assert flush and then rst_n=0 mid-sequence -> flush: busy_count=0 while staged we3 for rd=3 still appears; async reset: we3 drops immediately, busy_count=0, next both-valid grant goes to A.
